// File: rtl/coproc_pkg.sv
// rtl/coproc_pkg.sv - shared parameters, state type and helpers for the boot image row loader
package coproc_pkg;

    localparam int PIX_W         = 12;
    localparam int ROW_PIX       = 256;
    localparam int ROW_BITS      = PIX_W * ROW_PIX;
    localparam int ADDR_W        = 9;
    localparam int BYTES_PER_ROW = 3 * ROW_PIX / 2;
    localparam int NUM_ROWS_W    = 10;
    localparam int MAX_ROWS      = 1 << ADDR_W;
    localparam int BCNT_W        = 9;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WRITE,
        FIN
    } ldr_state_t;

    // Requests beyond the buffer depth load the whole buffer once.
    function automatic logic [NUM_ROWS_W-1:0] clamp_rows(input logic [NUM_ROWS_W-1:0] n);
        if (n > NUM_ROWS_W'(MAX_ROWS)) begin
            return NUM_ROWS_W'(MAX_ROWS);
        end
        return n;
    endfunction

endpackage

// File: rtl/rgb444_unpack.sv
// rtl/rgb444_unpack.sv - splits three stream bytes into two RGB444 pixels
module rgb444_unpack
    import coproc_pkg::*;
(
    input  logic [7:0]       b0,
    input  logic [7:0]       b1,
    input  logic [7:0]       b2,
    output logic [PIX_W-1:0] pix_a,
    output logic [PIX_W-1:0] pix_b
);

    // The middle byte is shared: its high nibble ends pixel A, its low nibble starts pixel B.
    assign pix_a = {b0, b1[7:4]};
    assign pix_b = {b1[3:0], b2};

endmodule

// File: rtl/img_row_loader.sv
// rtl/img_row_loader.sv - assembles streamed RGB444 bytes into buffer rows and writes them via the boot port
module img_row_loader
    import coproc_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [NUM_ROWS_W-1:0] num_rows,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  we_boot,
    output logic [ROW_BITS-1:0]   wdata_boot,
    output logic [ADDR_W-1:0]     waddr_boot,
    output logic                  bootloading
);

    ldr_state_t            state_q, state_d;
    logic [1:0]            phase_q, phase_d;
    logic [BCNT_W-1:0]     byte_cnt_q, byte_cnt_d;
    logic [7:0]            b0_q, b0_d;
    logic [7:0]            b1_q, b1_d;
    logic [ROW_BITS-1:0]   row_q, row_d;
    logic [ADDR_W-1:0]     row_addr_q, row_addr_d;
    logic [NUM_ROWS_W-1:0] rows_left_q, rows_left_d;
    logic                  in_ready_q, in_ready_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  we_boot_q, we_boot_d;
    logic                  boot_q, boot_d;

    logic [PIX_W-1:0]      pix_a;
    logic [PIX_W-1:0]      pix_b;
    logic                  xfer;

    // The third byte of a pair is unpacked straight off the input so the shift happens on its transfer.
    rgb444_unpack u_unpack (
        .b0    (b0_q),
        .b1    (b1_q),
        .b2    (in_data),
        .pix_a (pix_a),
        .pix_b (pix_b)
    );

    // in_ready_q mirrors the LOAD state, so it doubles as the accept qualifier.
    assign xfer = in_valid && in_ready_q;

    // Next-state, counters, row assembly and next values of the registered outputs.
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        byte_cnt_d  = byte_cnt_q;
        b0_d        = b0_q;
        b1_d        = b1_q;
        row_d       = row_q;
        row_addr_d  = row_addr_q;
        rows_left_d = rows_left_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    phase_d     = 2'd0;
                    byte_cnt_d  = '0;
                    row_addr_d  = '0;
                    rows_left_d = clamp_rows(num_rows);
                    state_d     = (num_rows == '0) ? FIN : LOAD;
                end
            end
            LOAD: begin
                if (xfer) begin
                    case (phase_q)
                        2'd0: begin
                            b0_d    = in_data;
                            phase_d = 2'd1;
                        end
                        2'd1: begin
                            b1_d    = in_data;
                            phase_d = 2'd2;
                        end
                        default: begin
                            // New pair enters at the top; after a full row pixel 0 sits at the LSB.
                            row_d   = {pix_b, pix_a, row_q[ROW_BITS-1:2*PIX_W]};
                            phase_d = 2'd0;
                        end
                    endcase
                    if (byte_cnt_q == BCNT_W'(BYTES_PER_ROW - 1)) begin
                        byte_cnt_d = '0;
                        state_d    = WRITE;
                    end else begin
                        byte_cnt_d = byte_cnt_q + BCNT_W'(1);
                    end
                end
            end
            WRITE: begin
                row_addr_d  = row_addr_q + ADDR_W'(1);
                rows_left_d = rows_left_q - NUM_ROWS_W'(1);
                state_d     = (rows_left_q == NUM_ROWS_W'(1)) ? FIN : LOAD;
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they line up with the state they describe.
        in_ready_d = (state_d == LOAD);
        busy_d     = (state_d == LOAD) || (state_d == WRITE);
        boot_d     = (state_d == LOAD) || (state_d == WRITE);
        we_boot_d  = (state_d == WRITE);
        done_d     = (state_d == FIN);
    end

    // State, datapath and output registers; reset discards any partial row.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            phase_q     <= 2'd0;
            byte_cnt_q  <= '0;
            b0_q        <= '0;
            b1_q        <= '0;
            row_q       <= '0;
            row_addr_q  <= '0;
            rows_left_q <= '0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            we_boot_q   <= 1'b0;
            boot_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            byte_cnt_q  <= byte_cnt_d;
            b0_q        <= b0_d;
            b1_q        <= b1_d;
            row_q       <= row_d;
            row_addr_q  <= row_addr_d;
            rows_left_q <= rows_left_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            we_boot_q   <= we_boot_d;
            boot_q      <= boot_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign we_boot     = we_boot_q;
    assign wdata_boot  = row_q;
    assign waddr_boot  = row_addr_q;
    assign bootloading = boot_q;

endmodule

// File: tb/tb_img_row_loader.sv
// tb/tb_img_row_loader.sv - self-checking bench for the boot image row loader
module tb_img_row_loader;
    import coproc_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  start;
    logic [NUM_ROWS_W-1:0] num_rows;
    logic [7:0]            in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic                  busy;
    logic                  done;
    logic                  we_boot;
    logic [ROW_BITS-1:0]   wdata_boot;
    logic [ADDR_W-1:0]     waddr_boot;
    logic                  bootloading;

    img_row_loader dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .num_rows    (num_rows),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .busy        (busy),
        .done        (done),
        .we_boot     (we_boot),
        .wdata_boot  (wdata_boot),
        .waddr_boot  (waddr_boot),
        .bootloading (bootloading)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    typedef struct {
        int                  cyc;
        logic [ADDR_W-1:0]   addr;
        logic [ROW_BITS-1:0] data;
    } wr_t;

    wr_t                 wq[$];
    logic [7:0]          rowbytes[$];
    int                  wlog[$];
    bit                  m_busy = 0;
    int                  m_start_cyc = 0;
    int                  m_done_cyc = -1;
    int                  m_rows = 0;
    int                  m_left = 0;
    int                  m_row_idx = 0;
    int                  wr_count = 0;
    logic [ROW_BITS-1:0] last_wdata = '0;
    int                  last_done_cyc = -1;
    int                  last_we_cyc = -1;
    int                  last_xfer_cyc = -1;
    int                  boot_rises = 0;
    int                  boot_rise_cyc = -1;
    int                  boot_fall_cyc = -1;
    int                  ro_low = 0;
    logic                boot_prev = 1'b0;
    int                  s_cyc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_row(input logic [ROW_BITS-1:0] a, input logic [ROW_BITS-1:0] e);
        int bad;
        bad = -1;
        n_cmp++;
        for (int p = 0; p < ROW_PIX; p++) begin
            if (bad < 0 && a[12*p +: 12] !== e[12*p +: 12]) bad = p;
        end
        if (bad >= 0) begin
            n_bad++;
            $display("FAIL wdata pixel %0d: got %03h, want %03h (cycle %0d)",
                     bad, a[12*bad +: 12], e[12*bad +: 12], cyc);
        end
    endtask

    // Expected row straight from the byte-pair packing rule.
    function automatic logic [ROW_BITS-1:0] pack_row();
        logic [ROW_BITS-1:0] r;
        logic [7:0] x0, x1, x2;
        r = '0;
        for (int k = 0; k < ROW_PIX / 2; k++) begin
            x0 = rowbytes[3*k];
            x1 = rowbytes[3*k+1];
            x2 = rowbytes[3*k+2];
            r[24*k +: 12]      = {x0, x1[7:4]};
            r[24*k + 12 +: 12] = {x1[3:0], x2};
        end
        return r;
    endfunction

    function automatic logic [7:0] byte_at(input int mode, input int i);
        logic [11:0] pa, pb;
        int ph;
        ph = i % 3;
        pa = 12'(2 * (i / 3));
        pb = 12'(2 * (i / 3) + 1);
        if (mode == 0) return (ph == 0) ? 8'hAB : (ph == 1) ? 8'hCD : 8'hEF;
        if (mode == 1) return (ph == 0) ? pa[11:4] : (ph == 1) ? {pa[3:0], pb[11:8]} : pb[7:0];
        return 8'($urandom);
    endfunction

    function automatic bit pattern_ok(input logic [ROW_BITS-1:0] r);
        for (int p = 0; p < ROW_PIX; p++) begin
            if (r[12*p +: 12] !== ((p % 2 == 0) ? 12'hABC : 12'hDEF)) return 0;
        end
        return 1;
    endfunction

    // Reference model and per-cycle compare, sampled on the falling edge.
    initial begin
        bit   wr_now, act, was_busy;
        wr_t  w;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                wq.delete();
                rowbytes.delete();
                m_busy     = 0;
                m_done_cyc = -1;
                boot_prev  = 1'b0;
            end else begin
                wr_now = 0;
                if (wq.size() > 0) wr_now = (wq[0].cyc == cyc);
                act = m_busy && (cyc > m_start_cyc) && (m_rows > 0) &&
                      (m_done_cyc < 0 || cyc < m_done_cyc);
                chk("busy", busy, act);
                chk("bootloading", bootloading, act);
                chk("in_ready", in_ready, act && !wr_now);
                chk("done", done, m_busy && cyc == m_done_cyc);
                chk("we_boot", we_boot, wr_now);
                if (wr_now) begin
                    chk("waddr", waddr_boot, wq[0].addr);
                    chk_row(wdata_boot, wq[0].data);
                    void'(wq.pop_front());
                end
                if (we_boot) begin
                    wr_count++;
                    last_wdata  = wdata_boot;
                    last_we_cyc = cyc;
                    wlog.push_back(int'(waddr_boot));
                end
                if (done) last_done_cyc = cyc;
                if (bootloading && !boot_prev) begin
                    boot_rises++;
                    boot_rise_cyc = cyc;
                end
                if (!bootloading && boot_prev) boot_fall_cyc = cyc;
                if (bootloading && !in_ready) ro_low++;
                boot_prev = bootloading;

                was_busy = m_busy;
                if (m_busy && cyc == m_done_cyc) m_busy = 0;
                if (in_valid && in_ready) begin
                    last_xfer_cyc = cyc;
                    rowbytes.push_back(in_data);
                    if (rowbytes.size() == BYTES_PER_ROW) begin
                        w.cyc  = cyc + 1;
                        w.addr = ADDR_W'(m_row_idx % MAX_ROWS);
                        w.data = pack_row();
                        wq.push_back(w);
                        rowbytes.delete();
                        m_row_idx++;
                        m_left--;
                        if (m_left == 0) m_done_cyc = cyc + 2;
                    end
                end
                if (start && !was_busy) begin
                    m_busy      = 1;
                    m_start_cyc = cyc;
                    m_rows      = (int'(num_rows) > MAX_ROWS) ? MAX_ROWS : int'(num_rows);
                    m_left      = m_rows;
                    m_row_idx   = 0;
                    rowbytes.delete();
                    m_done_cyc  = (m_rows == 0) ? cyc + 1 : -1;
                end
            end
        end
    end

    task automatic pulse_start(input int n);
        start    = 1'b1;
        num_rows = NUM_ROWS_W'(n);
        s_cyc    = cyc + 1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic send_stream(input int n, input int mode, input bit gaps);
        bit acc;
        int tmo;
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            in_valid = 1'b1;
            in_data  = byte_at(mode, i);
            tmo = 0;
            acc = 0;
            while (!acc && tmo < 50) begin
                @(negedge clk);
                acc = in_ready;
                @(posedge clk);
                #1;
                tmo++;
            end
            if (!acc) begin
                chk("accept_timeout", 0, 1);
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_done();
        bit got;
        got = 0;
        for (int i = 0; i < 3000 && !got; i++) begin
            @(negedge clk);
            got = done;
        end
        chk("done_seen", got, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int w0, b0;
        bit ok;
        rst = 1'b1; start = 1'b0; num_rows = '0; in_data = '0; in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_we_boot", we_boot, 0);
        chk("rst_bootloading", bootloading, 0);
        chk("rst_waddr", waddr_boot, 0);
        chk("rst_wdata_zero", wdata_boot == '0, 1);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Abort a load part way, then load one clean row.
        w0 = wr_count;
        pulse_start(2);
        send_stream(100, 2, 0);
        rst = 1'b1;
        #1;
        chk("t1_async_bootloading", bootloading, 0);
        chk("t1_async_busy", busy, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("t1_abort_no_write", wr_count - w0, 0);
        wlog.delete();
        pulse_start(1);
        send_stream(BYTES_PER_ROW, 0, 0);
        wait_done();
        chk("t1_writes", wr_count - w0, 1);
        chk("t1_waddr", (wlog.size() > 0) ? wlog[0] : -1, 0);
        chk("t1_no_residue", pattern_ok(last_wdata), 1);

        // One row of AB CD EF: latency and done timing.
        w0 = wr_count;
        pulse_start(1);
        send_stream(BYTES_PER_ROW, 0, 0);
        wait_done();
        chk("t2_writes", wr_count - w0, 1);
        chk("t2_pix0", last_wdata[11:0], 12'hABC);
        chk("t2_pix1", last_wdata[23:12], 12'hDEF);
        chk("t2_all_pairs", pattern_ok(last_wdata), 1);
        chk("t2_latency", last_we_cyc - last_xfer_cyc, 1);
        chk("t2_done_after_we", last_done_cyc - last_we_cyc, 1);

        // Two rows with in_valid held high.
        w0 = wr_count;
        wlog.delete();
        ro_low = 0;
        pulse_start(2);
        b0 = s_cyc;
        send_stream(2 * BYTES_PER_ROW, 1, 0);
        wait_done();
        chk("t3_writes", wr_count - w0, 2);
        chk("t3_waddr0", (wlog.size() > 0) ? wlog[0] : -1, 0);
        chk("t3_waddr1", (wlog.size() > 1) ? wlog[1] : -1, 1);
        chk("t3_ready_low_cycles", ro_low, 2);
        chk("t3_boot_rise", boot_rise_cyc, b0 + 1);
        chk("t3_boot_fall_at_done", boot_fall_cyc, last_done_cyc);

        // Zero rows: done only.
        w0 = wr_count;
        b0 = boot_rises;
        pulse_start(0);
        wait_done();
        chk("t4_done_cycle", last_done_cyc, s_cyc + 1);
        chk("t4_no_boot", boot_rises - b0, 0);
        chk("t4_no_write", wr_count - w0, 0);

        // Three rows with gaps and a stray start mid-load.
        w0 = wr_count;
        pulse_start(3);
        fork
            send_stream(3 * BYTES_PER_ROW, 1, 1);
            begin
                repeat (300) @(posedge clk);
                #1;
                start = 1'b1;
                num_rows = NUM_ROWS_W'(5);
                @(posedge clk);
                #1;
                start = 1'b0;
            end
        join
        wait_done();
        chk("t5_writes", wr_count - w0, 3);
        chk("t5_last_pix", last_wdata[12*255 +: 12], 12'h2FF);
        chk("t5_first_pix", last_wdata[11:0], 12'h200);

        // Oversized request: rows stream in address order until reset cuts it short.
        w0 = wr_count;
        wlog.delete();
        pulse_start(700);
        send_stream(64 * BYTES_PER_ROW, 1, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("t6_writes", wr_count - w0, 64);
        ok = (wlog.size() == 64);
        for (int i = 0; i < wlog.size(); i++) if (wlog[i] != i) ok = 0;
        chk("t6_addr_order", ok, 1);
        chk("t6_still_busy", busy, 1);
        send_stream(100, 1, 0);
        rst = 1'b1;
        #1;
        chk("t6_async_bootloading", bootloading, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("t6_idle_in_ready", in_ready, 0);
        chk("t6_partial_dropped", wr_count - w0, 64);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1);
    end

endmodule
